// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is fed LSB-first from operand
// shift registers, with the carry held in a flip-flop between bits.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum, fa_carry;
  logic             load, last;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // A 1-bit result has no older sum bits to shift down.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign s_next = fa_sum;
    end else begin : g_wide
      assign s_next = {fa_sum, s_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      a_sr    <= a;
      b_sr    <= b;
      s_sr    <= '0;
      carry_q <= cin;
      cnt     <= '0;
    end else if (state_q == SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      s_sr    <= s_next;
      carry_q <= fa_carry;
      cnt     <= cnt + 1'b1;
      if (last) begin
        sum  <= s_next;
        cout <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=8 instance for directed scenarios and a
// WIDTH=3 instance for an exhaustive sweep, checked through result queues.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start3 = 1'b0, cin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;

  logic [8:0] q8[$];
  logic [3:0] q3[$];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start one WIDTH=8 operation and follow it to its done pulse.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input string name);
    logic [8:0] exp;
    int cycles, busy_cnt;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'b0, c});
    tick;
    start8 = 1'b0;
    cycles = 0; busy_cnt = 0;
    while (!done8 && cycles < 40) begin
      if (busy8) busy_cnt++;
      tick;
      cycles++;
    end
    n_cmp++;
    if (cycles !== 8) begin
      n_fail++; $display("FAIL %s latency: got %0d cycles, want 8", name, cycles);
    end
    n_cmp++;
    if (busy_cnt !== 8) begin
      n_fail++; $display("FAIL %s busy_len: got %0d, want 8", name, busy_cnt);
    end
    n_cmp++;
    if (q8.size() == 0) begin
      n_fail++; $display("FAIL %s scoreboard: got empty queue, want 1 entry", name);
    end else begin
      exp = q8.pop_front();
      if ({cout8, sum8} !== exp) begin
        n_fail++; $display("FAIL %s result: got %h, want %h", name, {cout8, sum8}, exp);
      end
    end
    tick;
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL %s pulse_end: got done=%b busy=%b, want 0 0", name, done8, busy8);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    n_cmp++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      n_fail++; $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    n_cmp++;
    if ({busy3, done3, cout3, sum3} !== 6'd0) begin
      n_fail++; $display("FAIL reset3: got busy=%b done=%b cout=%b sum=%h, want all 0", busy3, done3, cout3, sum3);
    end
    rst_n = 1'b1;
    tick;
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_basic;
    run8(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    run8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
    run8(8'h00, 8'h00, 1'b1, "add_cin_only");
    n_cmp++;
    if (sum8 !== 8'h01 || cout8 !== 1'b0) begin
      n_fail++; $display("FAIL hold_idle: got sum=%h cout=%b, want 01 0", sum8, cout8);
    end
  endtask

  task automatic test_start_ignored;
    logic [8:0] exp;
    int cycles;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h010);
    tick;
    start8 = 1'b0;
    cycles = 0;
    tick; cycles++;
    tick; cycles++;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    tick; cycles++;
    start8 = 1'b0;
    n_cmp++;
    if (sum8 !== 8'h01) begin
      n_fail++; $display("FAIL hold_during_shift: got sum=%h, want 01", sum8);
    end
    while (!done8 && cycles < 40) begin
      tick;
      cycles++;
    end
    n_cmp++;
    if (cycles !== 8) begin
      n_fail++; $display("FAIL ignored_start latency: got %0d, want 8", cycles);
    end
    n_cmp++;
    exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
    if ({cout8, sum8} !== exp) begin
      n_fail++; $display("FAIL ignored_start result: got %h, want %h", {cout8, sum8}, exp);
    end
    tick;
    tick;
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL ignored_start not_queued: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp;
    int gap, want;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h002);
    tick;
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      if (k > 0) begin
        tick;
        gap = 1;
      end
      while (!done8 && gap < 40) begin
        n_cmp++;
        if (busy8 !== 1'b1) begin
          n_fail++; $display("FAIL b2b busy k=%0d gap=%0d: got 0, want 1", k, gap);
        end
        tick;
        gap++;
      end
      want = (k == 0) ? 8 : 9;
      n_cmp++;
      if (gap !== want || busy8 !== 1'b0) begin
        n_fail++; $display("FAIL b2b period k=%0d: got gap=%0d busy=%b, want %0d 0", k, gap, busy8, want);
      end
      n_cmp++;
      exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
      if ({cout8, sum8} !== exp) begin
        n_fail++; $display("FAIL b2b result k=%0d: got %h, want %h", k, {cout8, sum8}, exp);
      end
      if (k < 2) q8.push_back(9'h002);
      else start8 = 1'b0;
    end
    tick;
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL b2b stop: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    run8(8'h5A, 8'h3C, 1'b0, "pre_abort");
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    tick; tick; tick;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      n_fail++; $display("FAIL abort: got busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy8, done8, sum8, cout8);
    end
    tick;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done8 || busy8) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abort no_done: got %0d active cycles, want 0", seen);
    end
    run8(8'h10, 8'h20, 1'b0, "post_abort");
  endtask

  task automatic test_sweep_w3;
    logic [3:0] exp;
    int cycles, busy_cnt;
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a3 = 3'(ia); b3 = 3'(ib); cin3 = 1'(ic); start3 = 1'b1;
          q3.push_back(4'(ia + ib + ic));
          tick;
          start3 = 1'b0;
          cycles = 0; busy_cnt = 0;
          while (!done3 && cycles < 20) begin
            if (busy3) busy_cnt++;
            tick;
            cycles++;
          end
          n_cmp++;
          if (cycles !== 3 || busy_cnt !== 3) begin
            n_fail++; $display("FAIL w3 timing a=%0d b=%0d c=%0d: got %0d/%0d, want 3/3", ia, ib, ic, cycles, busy_cnt);
          end
          n_cmp++;
          exp = (q3.size() != 0) ? q3.pop_front() : 4'hF;
          if ({cout3, sum3} !== exp || q3.size() != 0) begin
            n_fail++; $display("FAIL w3 result a=%0d b=%0d c=%0d: got %h, want %h", ia, ib, ic, {cout3, sum3}, exp);
          end
          tick;
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    test_sweep_w3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
